// File: rtl/vga_sync_timing.sv
// 640x480@60 VGA sync/coordinate generator advanced by the rising edge of a sampled pixel clock.
// Define VGA_SYNC_INTERNAL_DIV_EN to ignore pix_in and advance from an internal divide-by-2 toggle.
module vga_sync_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_in,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] Y_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic       advance;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
  logic       line_start_q, line_start_d, frame_start_q, frame_start_d;

`ifdef VGA_SYNC_INTERNAL_DIV_EN
  logic div_q, div_d;
  logic unused_pix;
  assign unused_pix = pix_in;
  assign div_d      = ~div_q;
  assign advance    = div_q;

  always_ff @(posedge clk) begin
    if (rst) div_q <= 1'b0;
    else     div_q <= div_d;
  end
`else
  logic pix_prev_q, pix_prev_d;
  assign pix_prev_d = pix_in;
  assign advance    = pix_in & ~pix_prev_q;

  // Reset high so a pixel clock already high at release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) pix_prev_q <= 1'b1;
    else     pix_prev_q <= pix_prev_d;
  end
`endif

  // Outputs are decoded from the next counter values so they land with the counters.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (advance) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    hsync_d       = !((x_d >= HS_BEG) && (x_d <= HS_END));
    vsync_d       = !((y_d >= VS_BEG) && (y_d <= VS_END));
    video_on_d    = (x_d < X_VIS) && (y_d < Y_VIS);
    line_start_d  = advance && (x_d == '0);
    frame_start_d = line_start_d && (y_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q           <= X_LAST;
      y_q           <= Y_LAST;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_timing.sv
// Directed bench for vga_sync_timing: full-size instance for line timing, a shrunken instance for frame timing.
module tb_vga_sync_timing;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_in = 1'b0;
  logic       pix_s = 1'b0;

  logic       hsync, vsync, video_on, line_start, frame_start;
  logic [9:0] x, y;
  logic       hsync_s, vsync_s, video_on_s, line_start_s, frame_start_s;
  logic [9:0] x_s, y_s;

  int n_cmp = 0;
  int n_bad = 0;
  int hs_low = 0;

  always #5 clk = ~clk;

  vga_sync_timing dut (
    .clk(clk), .rst(rst), .pix_in(pix_in),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start)
  );

  // 8 pixels x 7 lines: hsync low at x=5..6, vsync low at y=4..5, visible 4x3.
  vga_sync_timing #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_s (
    .clk(clk), .rst(rst), .pix_in(pix_s),
    .hsync(hsync_s), .vsync(vsync_s), .video_on(video_on_s),
    .x(x_s), .y(y_s), .line_start(line_start_s), .frame_start(frame_start_s)
  );

  typedef struct {
    int         n;
    logic [9:0] ex, ey;
    logic       hs, vs, vo, ls, fs;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_main(input string nm, input logic [9:0] ex, input logic [9:0] ey,
                          input logic hs, input logic vs, input logic vo,
                          input logic ls, input logic fs);
    n_cmp++;
    if ({x, y, hsync, vsync, video_on, line_start, frame_start} !== {ex, ey, hs, vs, vo, ls, fs}) begin
      n_bad++;
      $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b vo=%b ls=%b fs=%b expected x=%0d y=%0d hs=%b vs=%b vo=%b ls=%b fs=%b",
               nm, x, y, hsync, vsync, video_on, line_start, frame_start, ex, ey, hs, vs, vo, ls, fs);
    end
  endtask

  task automatic adv_main(input int n);
    for (int i = 0; i < n; i++) begin
      pix_in = 1'b0;
      @(posedge clk); #1;
      pix_in = 1'b1;
      @(posedge clk); #1;
      if (hsync === 1'b0) hs_low++;
    end
  endtask

  task automatic adv_small();
    pix_s = 1'b0;
    @(posedge clk); #1;
    pix_s = 1'b1;
    @(posedge clk); #1;
  endtask

  vec_t vecs[10];

  initial begin
    int ex, ey, vs_low, fs_cnt, strobe_seen;
    vecs[0] = '{0,   10'd799, 10'd524, 1, 1, 0, 0, 0};
    vecs[1] = '{1,   10'd0,   10'd0,   1, 1, 1, 1, 1};
    vecs[2] = '{639, 10'd639, 10'd0,   1, 1, 1, 0, 0};
    vecs[3] = '{1,   10'd640, 10'd0,   1, 1, 0, 0, 0};
    vecs[4] = '{15,  10'd655, 10'd0,   1, 1, 0, 0, 0};
    vecs[5] = '{1,   10'd656, 10'd0,   0, 1, 0, 0, 0};
    vecs[6] = '{95,  10'd751, 10'd0,   0, 1, 0, 0, 0};
    vecs[7] = '{1,   10'd752, 10'd0,   1, 1, 0, 0, 0};
    vecs[8] = '{47,  10'd799, 10'd0,   1, 1, 0, 0, 0};
    vecs[9] = '{1,   10'd0,   10'd1,   1, 1, 1, 1, 0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Shrunken instance: two full frames plus one advance, checked against index arithmetic.
    chk("small_reset", {x_s, y_s, hsync_s, vsync_s, video_on_s, line_start_s, frame_start_s},
        {10'd7, 10'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    vs_low = 0;
    fs_cnt = 0;
    for (int k = 1; k <= 113; k++) begin
      adv_small();
      ex = (k - 1) % 8;
      ey = ((k - 1) / 8) % 7;
      if (vsync_s === 1'b0) vs_low++;
      if (frame_start_s === 1'b1) fs_cnt++;
      if ({x_s, y_s, hsync_s, vsync_s, video_on_s, line_start_s, frame_start_s} !==
          {10'(ex), 10'(ey), !(ex >= 5 && ex <= 6), !(ey >= 4 && ey <= 5),
           (ex < 4 && ey < 3), (ex == 0), (ex == 0 && ey == 0)}) begin
        n_bad++;
        $display("FAIL small_adv%0d: got x=%0d y=%0d hs=%b vs=%b vo=%b ls=%b fs=%b expected x=%0d y=%0d",
                 k, x_s, y_s, hsync_s, vsync_s, video_on_s, line_start_s, frame_start_s, ex, ey);
      end
      n_cmp++;
    end
    chk("small_vsync_low_count", 32'(vs_low), 32'd32);
    chk("small_frame_start_count", 32'(fs_cnt), 32'd3);

    // Main instance has seen no pix_in edge so far and must still be frozen at reset state.
    for (int i = 0; i < 10; i++) begin
      adv_main(vecs[i].n);
      chk_main($sformatf("line_vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].hs,
               vecs[i].vs, vecs[i].vo, vecs[i].ls, vecs[i].fs);
    end
    chk("hsync_low_advances", 32'(hs_low), 32'd96);

    // Hold pix_in high: nothing moves, then one clean edge gives a single strobe.
    adv_main(799);
    chk_main("line1_end", 10'd799, 10'd1, 1, 1, 0, 0, 0);
    strobe_seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (line_start !== 1'b0 || x !== 10'd799) strobe_seen++;
    end
    chk("hold_high_frozen", 32'(strobe_seen), 32'd0);
    adv_main(1);
    chk_main("edge_after_hold", 10'd0, 10'd2, 1, 1, 1, 1, 0);
    @(posedge clk); #1;
    chk_main("strobe_one_clk", 10'd0, 10'd2, 1, 1, 1, 0, 0);
    @(posedge clk); #1;
    chk_main("strobe_stays_low", 10'd0, 10'd2, 1, 1, 1, 0, 0);

    // Mid-line reset coinciding with a pix_in rising edge: reset must win.
    adv_main(300);
    chk_main("pre_reset_pos", 10'd300, 10'd2, 1, 1, 1, 0, 0);
    pix_in = 1'b0;
    @(posedge clk); #1;
    pix_in = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_main("mid_reset", 10'd799, 10'd524, 1, 1, 0, 0, 0);
    @(posedge clk); #1;
    chk_main("no_adv_high_at_release", 10'd799, 10'd524, 1, 1, 0, 0, 0);
    adv_main(1);
    chk_main("first_after_reset", 10'd0, 10'd0, 1, 1, 1, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_timing.md
# vga_sync_timing

Pixel-timing consumer for the 640x480@60 Hz VGA output path. It runs on the 50 MHz system clock and samples the divided 25 MHz pixel clock as data, never as a clock. Each rising edge of that signal becomes a one-cycle advance enable. On each advance the block steps horizontal and vertical counters and produces registered hsync, vsync, video_on, pixel coordinates and line/frame start strobes for the filter and readout logic.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- clk  input  1  system clock, 50 MHz; all logic on posedge
- rst  input  1  synchronous, active-high reset
- pix_in  input  1  divided pixel clock, sampled as data; ignored when the internal divider is compiled in
- hsync  output  1  horizontal sync, active low, registered
- vsync  output  1  vertical sync, active low, registered
- video_on  output  1  high while (x, y) is inside the visible area
- x  output  10  current horizontal count
- y  output  10  current vertical count
- line_start  output  1  one-clk pulse when x becomes 0
- frame_start  output  1  one-clk pulse when (x, y) becomes (0, 0)

## Operation
- Derived constants: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). Both must be ≤ 1024 so the counters fit in 10 bits.
- Edge detect:
  - pix_prev <= pix_in every clk.
  - advance = pix_in & ~pix_prev.
- On a clk edge with advance = 1:
  - x increments. At x = H_TOTAL-1, x wraps to 0 and y increments.
  - At y = V_TOTAL-1, y wraps to 0.
- Without advance, x, y, hsync, vsync and video_on hold. line_start and frame_start are 0.
- Outputs are registered and always consistent with the current (x, y):
  - hsync = 0 iff H_VISIBLE+H_FRONT ≤ x ≤ H_VISIBLE+H_FRONT+H_SYNC-1 (656..751).
  - vsync = 0 iff V_VISIBLE+V_FRONT ≤ y ≤ V_VISIBLE+V_FRONT+V_SYNC-1 (490..491).
  - video_on = (x < H_VISIBLE) && (y < V_VISIBLE).
- Implementation: compute next-state values from the next counter values and register them together with the counters.
- line_start = 1 for exactly the clk cycle in which x first shows 0. frame_start additionally requires y = 0.
- Reset values:
  - x = H_TOTAL-1 (799), y = V_TOTAL-1 (524).
  - hsync = 1, vsync = 1, video_on = 0.
  - line_start = 0, frame_start = 0.
  - pix_prev = 1, so a high pix_in at reset release does not cause a spurious advance.
  - The first advance after reset therefore lands on (0, 0) with both strobes asserted.
- Reset mid-frame: the state above is reached on the next clk edge regardless of counter position or advance.
- When rst and advance are both active, rst wins.

## Timing
- Advance latency: the counters and all outputs change on the clk edge where pix_in is sampled 1 and the previous sample was 0.
- There is no further pipeline delay; sync, video_on and coordinates are cycle-aligned.
- With a 50%-duty 25 MHz pix_in, there is one advance every 2 clk cycles.
- Line period = 800 advances; frame period = 420000 advances.
- Strobes are exactly 1 clk wide, never 2, even when pix_in is high for several cycles.
- pix_in held constant produces no advances; all outputs stay frozen.

## Configuration
- VGA_SYNC_INTERNAL_DIV_EN defined:
  - pix_in is ignored.
  - An internal toggle register div (reset 0, toggles every clk) generates advance = div. The first advance occurs on the 2nd clk after reset release, then every 2nd clk.
- VGA_SYNC_INTERNAL_DIV_EN undefined: advance comes from the pix_in edge detect as described under Operation.

## Test plan
- Reset, then pix_in toggling every clk:
  - First advance gives x = 0, y = 0, frame_start = 1, line_start = 1, video_on = 1, hsync = 1, vsync = 1.
  - 800 advances later: x = 0, y = 1, line_start = 1, frame_start = 0.
- Horizontal sync and blanking over one full line:
  - hsync = 0 for exactly x = 656..751 (96 advances).
  - video_on drops at x = 640.
- Vertical sync over a full frame:
  - vsync = 0 for exactly y = 490..491.
  - frame_start pulses once per 420000 advances.
  - y wraps from 524 to 0.
- pix_in held high for 10 clk: no change. One clean 0→1 transition then gives exactly one advance and a single 1-clk strobe.
- rst asserted for 1 clk at x = 300, y = 200: next cycle x = 799, y = 524, hsync = 1, vsync = 1, video_on = 0, strobes 0.
- With VGA_SYNC_INTERNAL_DIV_EN defined and pix_in tied 0: advances occur every 2nd clk; first at the 2nd clk after reset, giving x = 0, y = 0.
